// File: rtl/segre_pkg.sv
// Shared constants and types for the segre fetch/icache path.
package segre_pkg;

    localparam int unsigned ADDR_SIZE         = 32;
    localparam int unsigned ICACHE_LANE_SIZE  = 128;
    localparam int unsigned ICACHE_NUM_LANES  = 4;
    localparam int unsigned ICACHE_INDEX_SIZE = 2;
    localparam int unsigned ICACHE_BYTE_SIZE  = 4;

    typedef enum logic [1:0] {
        IC_RF_IDLE    = 2'd0,
        IC_RF_MEM_REQ = 2'd1,
        IC_RF_FILL    = 2'd2,
        IC_RF_SETTLE  = 2'd3
    } ic_refill_state_e;

    typedef struct packed {
        logic                        rd_req;
        logic [ADDR_SIZE-1:0]        addr;
        logic                        ready;
        logic [ICACHE_LANE_SIZE-1:0] data;
    } ic_refill_mem_t;

    // Memory fetches whole lines, so the byte offset inside the line is dropped.
    function automatic logic [ADDR_SIZE-1:0] line_align(input logic [ADDR_SIZE-1:0] a);
        return {a[ADDR_SIZE-1:ICACHE_BYTE_SIZE], {ICACHE_BYTE_SIZE{1'b0}}};
    endfunction

endpackage

// File: rtl/segre_lru_ages.sv
// Per-lane age tracking for the fully-associative icache.
// Age 0 is most recently used; ages stay a permutation of 0..ICACHE_NUM_LANES-1.
module segre_lru_ages
    import segre_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         touch_i,
    input  logic [ICACHE_INDEX_SIZE-1:0] touch_idx_i,
    input  logic [ICACHE_NUM_LANES-1:0]  valid_i,
    output logic [ICACHE_INDEX_SIZE-1:0] victim_o
);

    logic [ICACHE_INDEX_SIZE-1:0] age_q [ICACHE_NUM_LANES];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ICACHE_NUM_LANES; i++) begin
                age_q[i] <= ICACHE_INDEX_SIZE'(i);
            end
        end else if (touch_i) begin
            for (int i = 0; i < ICACHE_NUM_LANES; i++) begin
                if (ICACHE_INDEX_SIZE'(i) == touch_idx_i) begin
                    age_q[i] <= '0;
                end else if (age_q[i] < age_q[touch_idx_i]) begin
                    age_q[i] <= age_q[i] + 1'b1;
                end
            end
        end
    end

    // Oldest lane is the default; the descending scan lets the lowest invalid lane win.
    always_comb begin
        victim_o = '0;
        for (int i = 0; i < ICACHE_NUM_LANES; i++) begin
            if (age_q[i] == ICACHE_INDEX_SIZE'(ICACHE_NUM_LANES - 1)) begin
                victim_o = ICACHE_INDEX_SIZE'(i);
            end
        end
        for (int i = ICACHE_NUM_LANES - 1; i >= 0; i--) begin
            if (!valid_i[i]) begin
                victim_o = ICACHE_INDEX_SIZE'(i);
            end
        end
    end

endmodule

// File: rtl/segre_ic_refill.sv
// Icache miss refill engine: fetches a line from memory and fills a victim lane.
//   state         | meaning
//   IC_RF_IDLE    | accept hit touches, wait for a miss
//   IC_RF_MEM_REQ | line read outstanding, waiting for mem_ready_i
//   IC_RF_FILL    | one-cycle write strobe into tag/data arrays
//   IC_RF_SETTLE  | ignore the stale miss while the tag array updates
module segre_ic_refill
    import segre_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         ic_access_i,
    input  logic                         ic_miss_i,
    input  logic [ADDR_SIZE-1:0]         ic_addr_i,
    output logic                         mmu_data_o,
    output logic [ICACHE_LANE_SIZE-1:0]  mmu_wr_data_o,
    output logic [ICACHE_INDEX_SIZE-1:0] mmu_lru_index_o,
    output logic                         mem_rd_req_o,
    output logic [ADDR_SIZE-1:0]         mem_addr_o,
    input  logic                         mem_ready_i,
    input  logic [ICACHE_LANE_SIZE-1:0]  mem_data_i,
    output logic                         busy_o
);

    ic_refill_state_e             state_q, state_d;
    ic_refill_mem_t               mem;
    logic [ADDR_SIZE-1:0]         miss_addr_q;
    logic [ICACHE_INDEX_SIZE-1:0] victim_q;
    logic [ICACHE_LANE_SIZE-1:0]  line_q;
    logic [ICACHE_NUM_LANES-1:0]  valid_q;
    logic [ICACHE_INDEX_SIZE-1:0] lru_victim;
    logic                         new_miss;
    logic                         touch;
    logic [ICACHE_INDEX_SIZE-1:0] touch_idx;

    assign new_miss = (state_q == IC_RF_IDLE) && ic_access_i && ic_miss_i;

    // Hit touches only count in IDLE; the fill itself touches the victim.
    assign touch     = ((state_q == IC_RF_IDLE) && ic_access_i && !ic_miss_i)
                     || (state_q == IC_RF_FILL);
    assign touch_idx = (state_q == IC_RF_FILL) ? victim_q
                                               : ic_addr_i[ICACHE_INDEX_SIZE-1:0];

    segre_lru_ages u_lru_ages (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .touch_i     (touch),
        .touch_idx_i (touch_idx),
        .valid_i     (valid_q),
        .victim_o    (lru_victim)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IC_RF_IDLE;
            miss_addr_q <= '0;
            victim_q    <= '0;
            line_q      <= '0;
            valid_q     <= '0;
        end else begin
            state_q <= state_d;
            if (new_miss) begin
                miss_addr_q <= line_align(ic_addr_i);
                victim_q    <= lru_victim;
            end
            if ((state_q == IC_RF_MEM_REQ) && mem.ready) begin
                line_q <= mem.data;
            end
            if (state_q == IC_RF_FILL) begin
                valid_q[victim_q] <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IC_RF_IDLE:    if (new_miss) state_d = IC_RF_MEM_REQ;
            IC_RF_MEM_REQ: if (mem.ready) state_d = IC_RF_FILL;
            IC_RF_FILL:    state_d = IC_RF_SETTLE;
            IC_RF_SETTLE:  state_d = IC_RF_IDLE;
            default:       state_d = IC_RF_IDLE;
        endcase
    end

    always_comb begin
        mem        = '0;
        mem.ready  = mem_ready_i;
        mem.data   = mem_data_i;
        mem.rd_req = (state_q == IC_RF_MEM_REQ);
        mem.addr   = mem.rd_req ? miss_addr_q : '0;
        mmu_data_o = (state_q == IC_RF_FILL);
        busy_o     = (state_q != IC_RF_IDLE);
    end

    assign mem_rd_req_o    = mem.rd_req;
    assign mem_addr_o      = mem.addr;
    assign mmu_wr_data_o   = line_q;
    assign mmu_lru_index_o = victim_q;

endmodule

// File: tb/tb_segre_ic_refill.sv
// Randomized bench for segre_ic_refill against a recency-list reference model.
module tb_segre_ic_refill;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         ic_access_i = 1'b0;
    logic         ic_miss_i = 1'b0;
    logic [31:0]  ic_addr_i = '0;
    logic         mmu_data_o;
    logic [127:0] mmu_wr_data_o;
    logic [1:0]   mmu_lru_index_o;
    logic         mem_rd_req_o;
    logic [31:0]  mem_addr_o;
    logic         mem_ready_i = 1'b0;
    logic [127:0] mem_data_i = '0;
    logic         busy_o;

    int total = 0;
    int bad = 0;

    // Model: lanes ordered most-recent first; last entry is least recent.
    int order[$];
    bit [3:0] m_valid;

    segre_ic_refill dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .ic_access_i     (ic_access_i),
        .ic_miss_i       (ic_miss_i),
        .ic_addr_i       (ic_addr_i),
        .mmu_data_o      (mmu_data_o),
        .mmu_wr_data_o   (mmu_wr_data_o),
        .mmu_lru_index_o (mmu_lru_index_o),
        .mem_rd_req_o    (mem_rd_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_ready_i     (mem_ready_i),
        .mem_data_i      (mem_data_i),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic m_reset();
        m_valid = '0;
        order = {0, 1, 2, 3};
    endtask

    task automatic m_touch(input int k);
        for (int i = 0; i < order.size(); i++) begin
            if (order[i] == k) begin
                order.delete(i);
                break;
            end
        end
        order.push_front(k);
    endtask

    function automatic int m_victim();
        for (int i = 0; i < 4; i++) if (!m_valid[i]) return i;
        return order[order.size()-1];
    endfunction

    task automatic apply_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        ic_access_i = 1'b0;
        ic_miss_i = 1'b0;
        mem_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        m_reset();
    endtask

    // One complete refill; lat = MEM_REQ cycles before mem_ready_i.
    task automatic run_miss(input logic [31:0] addr, input int lat, input logic [127:0] data,
                            input bit stale, input bit noise, output int got_victim);
        int exp_v;
        int rd_cnt;
        int pulses;
        logic [31:0] exp_addr;
        exp_addr = {addr[31:4], 4'h0};
        @(negedge clk_i);
        exp_v = m_victim();
        ic_access_i = 1'b1;
        ic_miss_i = 1'b1;
        ic_addr_i = addr;
        @(negedge clk_i);
        if (!stale) begin
            ic_access_i = 1'b0;
            ic_miss_i = 1'b0;
        end
        rd_cnt = int'(mem_rd_req_o);
        pulses = int'(mmu_data_o);
        total++;
        if (mem_rd_req_o !== 1'b1 || mem_addr_o !== exp_addr) begin
            bad++;
            $display("FAIL mem_req: req=%b addr=%h, required req=1 addr=%h", mem_rd_req_o, mem_addr_o, exp_addr);
        end
        for (int i = 0; i < lat; i++) begin
            if (noise && !stale) begin
                ic_access_i = 1'($urandom_range(0, 1));
                ic_addr_i = $urandom;
            end
            @(negedge clk_i);
            rd_cnt += int'(mem_rd_req_o);
            pulses += int'(mmu_data_o);
            total++;
            if (mem_rd_req_o !== 1'b1 || mem_addr_o !== exp_addr) begin
                bad++;
                $display("FAIL mem_hold: req=%b addr=%h, required req=1 addr=%h", mem_rd_req_o, mem_addr_o, exp_addr);
            end
        end
        mem_ready_i = 1'b1;
        mem_data_i = data;
        @(negedge clk_i);
        mem_ready_i = 1'b0;
        mem_data_i = {$urandom, $urandom, $urandom, $urandom};
        rd_cnt += int'(mem_rd_req_o);
        pulses += int'(mmu_data_o);
        got_victim = int'(mmu_lru_index_o);
        total++;
        if (mmu_data_o !== 1'b1 || mmu_lru_index_o !== 2'(exp_v) || mmu_wr_data_o !== data) begin
            bad++;
            $display("FAIL fill: strobe=%b idx=%0d data=%h, required strobe=1 idx=%0d data=%h",
                     mmu_data_o, mmu_lru_index_o, mmu_wr_data_o, exp_v, data);
        end
        m_valid[exp_v] = 1'b1;
        m_touch(exp_v);
        @(negedge clk_i);
        rd_cnt += int'(mem_rd_req_o);
        pulses += int'(mmu_data_o);
        total++;
        if (busy_o !== 1'b1) begin
            bad++;
            $display("FAIL settle_busy: busy=%b, required 1", busy_o);
        end
        ic_access_i = 1'b0;
        ic_miss_i = 1'b0;
        @(negedge clk_i);
        rd_cnt += int'(mem_rd_req_o);
        pulses += int'(mmu_data_o);
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL idle_busy: busy=%b, required 0", busy_o);
        end
        total++;
        if (rd_cnt != lat + 1 || pulses != 1) begin
            bad++;
            $display("FAIL txn_count: req_cycles=%0d pulses=%0d, required req_cycles=%0d pulses=1",
                     rd_cnt, pulses, lat + 1);
        end
    endtask

    task automatic do_hit(input int lane);
        @(negedge clk_i);
        ic_access_i = 1'b1;
        ic_miss_i = 1'b0;
        ic_addr_i = ($urandom & 32'hFFFF_FFFC) | 32'(lane);
        @(negedge clk_i);
        ic_access_i = 1'b0;
        m_touch(lane);
        total++;
        if (busy_o !== 1'b0 || mem_rd_req_o !== 1'b0) begin
            bad++;
            $display("FAIL hit_no_refill: busy=%b req=%b, required 0 0", busy_o, mem_rd_req_o);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if (mmu_data_o !== 1'b0 || mem_rd_req_o !== 1'b0 || busy_o !== 1'b0 ||
            mmu_lru_index_o !== 2'd0 || mmu_wr_data_o !== 128'd0 || mem_addr_o !== 32'd0) begin
            bad++;
            $display("FAIL reset_outputs: strobe=%b req=%b busy=%b idx=%0d data=%h addr=%h, required all 0",
                     mmu_data_o, mem_rd_req_o, busy_o, mmu_lru_index_o, mmu_wr_data_o, mem_addr_o);
        end
    endtask

    task automatic test_cold_miss();
        int v;
        run_miss(32'h0000_1234, 3, 128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF, 1'b0, 1'b0, v);
        total++;
        if (v != 0) begin
            bad++;
            $display("FAIL cold_victim: got %0d, required 0", v);
        end
    endtask

    task automatic test_fill_order();
        int v;
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            run_miss(32'(i * 32'h100), 1 + i % 2, {4{$urandom}}, 1'b0, 1'b0, v);
            total++;
            if (v != exp_seq[i]) begin
                bad++;
                $display("FAIL fill_order[%0d]: got %0d, required %0d", i, v, exp_seq[i]);
            end
        end
    endtask

    task automatic test_hit_touch();
        int v;
        do_hit(0);
        run_miss(32'h0000_0500, 2, {4{$urandom}}, 1'b0, 1'b0, v);
        total++;
        if (v != 1) begin
            bad++;
            $display("FAIL hit_touch_a: got %0d, required 1", v);
        end
        do_hit(1);
        run_miss(32'h0000_0600, 0, {4{$urandom}}, 1'b0, 1'b0, v);
        total++;
        if (v != 2) begin
            bad++;
            $display("FAIL hit_touch_b: got %0d, required 2", v);
        end
    endtask

    task automatic test_stale_miss();
        int v;
        run_miss(32'h0000_0ABC, 2, {4{$urandom}}, 1'b1, 1'b0, v);
        repeat (3) begin
            @(negedge clk_i);
            total++;
            if (mem_rd_req_o !== 1'b0 || mmu_data_o !== 1'b0) begin
                bad++;
                $display("FAIL stale_after: req=%b strobe=%b, required 0 0", mem_rd_req_o, mmu_data_o);
            end
        end
    endtask

    task automatic test_zero_latency();
        int v;
        run_miss(32'h0000_7778, 0, {4{$urandom}}, 1'b0, 1'b0, v);
    endtask

    task automatic test_reset_mid();
        int v;
        @(negedge clk_i);
        ic_access_i = 1'b1;
        ic_miss_i = 1'b1;
        ic_addr_i = 32'h0000_9990;
        @(negedge clk_i);
        ic_access_i = 1'b0;
        ic_miss_i = 1'b0;
        rst_i = 1'b1;
        mem_ready_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        mem_ready_i = 1'b0;
        m_reset();
        total++;
        if (mem_rd_req_o !== 1'b0 || busy_o !== 1'b0 || mmu_data_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: req=%b busy=%b strobe=%b, required 0 0 0", mem_rd_req_o, busy_o, mmu_data_o);
        end
        repeat (3) begin
            @(negedge clk_i);
            total++;
            if (mmu_data_o !== 1'b0 || mem_rd_req_o !== 1'b0) begin
                bad++;
                $display("FAIL reset_mid_quiet: strobe=%b req=%b, required 0 0", mmu_data_o, mem_rd_req_o);
            end
        end
        run_miss(32'h0000_4444, 1, {4{$urandom}}, 1'b0, 1'b0, v);
        total++;
        if (v != 0) begin
            bad++;
            $display("FAIL reset_mid_victim: got %0d, required 0", v);
        end
    endtask

    task automatic test_random();
        int v;
        int r;
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 9);
            if (r < 4) begin
                do_hit($urandom_range(0, 3));
            end else if (r == 4) begin
                @(negedge clk_i);
                ic_access_i = 1'b0;
                ic_miss_i = 1'b1;
                ic_addr_i = $urandom;
                @(negedge clk_i);
                ic_miss_i = 1'b0;
                total++;
                if (busy_o !== 1'b0 || mem_rd_req_o !== 1'b0) begin
                    bad++;
                    $display("FAIL stray_miss: busy=%b req=%b, required 0 0", busy_o, mem_rd_req_o);
                end
            end else begin
                run_miss($urandom, $urandom_range(0, 4), {$urandom, $urandom, $urandom, $urandom},
                         1'($urandom_range(0, 1)), 1'b1, v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_fill_order();
        test_hit_touch();
        test_stale_miss();
        test_zero_latency();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/segre_ic_refill.md
Name: segre_ic_refill

Overview:
- Memory-side responder for instruction-cache misses raised by the fetch stage.
- Tracks per-lane validity and LRU order from fetch-stage access/hit reports.
- On a miss, fetches one lane-aligned line from main memory, picks a victim lane, and returns the line, the victim index and a one-cycle write strobe that fills the icache tag and data arrays.
- Sits between the fetch stage and the memory arbiter.

Parameters:
- ADDR_SIZE, 32, width of fetch and memory addresses.
- ICACHE_LANE_SIZE, 128, line width in bits.
- ICACHE_NUM_LANES, 4, number of fully-associative icache lanes.
- ICACHE_INDEX_SIZE, 2, log2(ICACHE_NUM_LANES).
- ICACHE_BYTE_SIZE, 4, log2 of line size in bytes; low address bits cleared for memory requests.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- ic_access_i  in  1  fetch stage performed an icache lookup this cycle.
- ic_miss_i  in  1  the lookup missed.
- ic_addr_i  in  ADDR_SIZE  on a miss, the fetch PC; on a hit, the hit lane index in bits [ICACHE_INDEX_SIZE-1:0].
- mmu_data_o  in  1  fill strobe to icache tag/data arrays, one cycle per fill.
- mmu_wr_data_o  out  ICACHE_LANE_SIZE  line written on mmu_data_o.
- mmu_lru_index_o  out  ICACHE_INDEX_SIZE  victim lane written on mmu_data_o.
- mem_rd_req_o  out  1  line read request to memory.
- mem_addr_o  out  ADDR_SIZE  line-aligned read address.
- mem_ready_i  in  1  memory returns mem_data_i this cycle.
- mem_data_i  in  ICACHE_LANE_SIZE  returned line.
- busy_o  out  1  refill in progress (state != IDLE).

(Correction: mmu_data_o direction is out.)

Behaviour:
Reset values:
- All outputs 0; state IDLE; all lanes invalid.
- Ages age[i] = i.

FSM states: IDLE, MEM_REQ, FILL, SETTLE.

IDLE:
- ic_access_i && !ic_miss_i: LRU touch of lane ic_addr_i[ICACHE_INDEX_SIZE-1:0]. No state change.
- ic_access_i && ic_miss_i:
  - Latch miss_addr = ic_addr_i with bits [ICACHE_BYTE_SIZE-1:0] cleared.
  - Latch victim: the lowest-numbered invalid lane if any exists, else the lane whose age == ICACHE_NUM_LANES-1.
  - Go to MEM_REQ.
- ic_miss_i without ic_access_i: ignored.

MEM_REQ:
- mem_rd_req_o = 1 and mem_addr_o = miss_addr, held stable until mem_ready_i.
- When mem_ready_i is sampled high:
  - Capture mem_data_i into the line register.
  - Deassert mem_rd_req_o next cycle.
  - Go to FILL.
- A memory latency of 0 extra cycles is legal: mem_ready_i may be high in the first MEM_REQ cycle.

FILL, exactly one cycle:
- mmu_data_o = 1, mmu_wr_data_o = line register, mmu_lru_index_o = victim.
- Set valid[victim].
- LRU touch of victim.
- Go to SETTLE.

SETTLE, one cycle:
- ic_access_i and ic_miss_i are ignored. This prevents a duplicate refill from the stale miss the fetch stage still presents while its tag array updates.
- Go to IDLE.

Outside FILL:
- mmu_data_o = 0.
- mmu_wr_data_o and mmu_lru_index_o hold their last values; they are don't-care.

LRU touch of lane k:
- Every lane j with age[j] < age[k] increments.
- age[k] becomes 0.
- Ages always remain a permutation of 0..ICACHE_NUM_LANES-1.
- Hit touches are accepted only in IDLE; touches arriving in other states are dropped.

Reset mid-operation:
- rst_i in any state returns to IDLE within the same edge.
- mem_rd_req_o is 0 the following cycle.
- A pending fill is discarded and no mmu_data_o pulse is issued.
- Valid bits and ages are reinitialised.

Decomposition:
- segre_pkg gains:
  - ic_refill_state_e {IC_RF_IDLE, IC_RF_MEM_REQ, IC_RF_FILL, IC_RF_SETTLE}.
  - A packed struct ic_refill_mem_t bundling rd_req, addr, ready and data.
- The lane and index constants already live there.
- Sub-module segre_lru_ages holds the age array, touch logic and victim selection including the invalid-first rule.
  - Ports: clk_i, rst_i, touch_i, touch_idx_i, valid_i, victim_o.

Test Plan:
1. Cold miss: rst_i high 2 cycles then low; ic_access_i=1, ic_miss_i=1, ic_addr_i=0x0000_1234 -> mem_rd_req_o=1 with mem_addr_o=0x0000_1230 next cycle; mem_ready_i after 3 cycles with data 0xDEAD..BEEF -> one-cycle mmu_data_o, mmu_lru_index_o=0, mmu_wr_data_o=that data.
2. Fill order: four misses to 0x000, 0x100, 0x200, 0x300 -> victims 0,1,2,3; fifth miss to 0x400 -> victim 0 (oldest).
3. Hit touches: after test 2, hit on lane 0 (ic_addr_i=0), then miss -> victim 1; hit on lane 1, then miss -> victim 2.
4. Stale miss: ic_miss_i held high through FILL and SETTLE -> exactly one mem_rd_req_o transaction and one mmu_data_o pulse.
5. Zero latency: mem_ready_i high in the first MEM_REQ cycle -> mmu_data_o asserted on the following cycle; mem_rd_req_o high for exactly one cycle.
6. Reset mid-request: rst_i asserted during MEM_REQ -> mem_rd_req_o=0 next cycle, no mmu_data_o; the next miss selects victim 0.
